// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = 32;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdState_t;

    // Two's-complement magnitude; the most negative value maps to itself as unsigned.
    function automatic logic [MD_WIDTH-1:0] absVal(input logic [MD_WIDTH-1:0] x);
        return x[MD_WIDTH-1] ? MD_WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then arithmetic shift right.
module booth_step #(
    parameter int unsigned W = 32
) (
    input  logic [2*W+1:0] acc,
    input  logic [W:0]     m,
    output logic [2*W+1:0] nextAcc
);

    logic [W:0] aPart;
    logic [W:0] aSum;

    always_comb begin
        aPart = acc[2*W+1:W+1];
        aSum  = aPart;
        case (acc[1:0])
            2'b01:   aSum = aPart + m;
            2'b10:   aSum = aPart - m;
            default: aSum = aPart;
        endcase
        nextAcc = {aSum[W], aSum, acc[W:1]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed Booth multiply / restoring divide serving the control FSM's MULT/DIV requests.
// Optional zero-divide trap enabled by defining MULT_DIV_DIV0_TRAP_EN.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(MD_ITERS);
    localparam int unsigned ACC_W = 2*WIDTH + 2;

    mdState_t         state;
    logic             opReg;
    logic [CNT_W-1:0] iterCnt;
    logic [ACC_W-1:0] work;
    logic [ACC_W-1:0] boothNext;
    logic [ACC_W-1:0] divNext;
    logic [WIDTH:0]   mReg;
    logic             negQuo;
    logic             negRem;

    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divFits;
    logic [WIDTH-1:0] remMag;
    logic [WIDTH-1:0] quoMag;

    booth_step #(.W(WIDTH)) uBoothStep (
        .acc     (work),
        .m       (mReg),
        .nextAcc (boothNext)
    );

    // Divide layout: remainder in work[2W-1:W], dividend/quotient in work[W-1:0].
    always_comb begin
        remMag   = work[2*WIDTH-1:WIDTH];
        quoMag   = work[WIDTH-1:0];
        divShift = {remMag, quoMag[WIDTH-1]};
        divFits  = divShift >= {1'b0, mReg[WIDTH-1:0]};
        divDiff  = divShift[WIDTH-1:0] - mReg[WIDTH-1:0];
        divNext  = {2'b00, divFits ? divDiff : divShift[WIDTH-1:0],
                    quoMag[WIDTH-2:0], divFits};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            opReg   <= OP_DIV;
            iterCnt <= '0;
            work    <= '0;
            mReg    <= '0;
            negQuo  <= 1'b0;
            negRem  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULT_DIV_DIV0_TRAP_EN
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg   <= op;
                        iterCnt <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                        if (op == OP_MULT) begin
                            work <= {{(WIDTH+1){1'b0}}, a, 1'b0};
                            mReg <= {b[WIDTH-1], b};
                        end else begin
                            work   <= {2'b00, {WIDTH{1'b0}}, absVal(a)};
                            mReg   <= {1'b0, absVal(b)};
                            negQuo <= a[WIDTH-1] ^ b[WIDTH-1];
                            negRem <= a[WIDTH-1];
                        end
`ifdef MULT_DIV_DIV0_TRAP_EN
                        if (op == OP_DIV && b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    work    <= (opReg == OP_MULT) ? boothNext : divNext;
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == CNT_W'(MD_ITERS - 1)) begin
                        if (opReg == OP_MULT) begin
                            hi    <= boothNext[2*WIDTH:WIDTH+1];
                            lo    <= boothNext[WIDTH:1];
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    hi    <= negRem ? WIDTH'(-remMag) : remMag;
                    lo    <= negQuo ? WIDTH'(-quoMag) : quoMag;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef MULT_DIV_DIV0_TRAP_EN
                    div_zero <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MULT_DIV_DIV0_TRAP_EN
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request at the current negedge; n counts rising edges after the start sample edge.
    task automatic runOp(input string tag, input logic opSel, input logic [31:0] aIn,
                         input logic [31:0] bIn, input int expLat, input logic [31:0] expHi,
                         input logic [31:0] expLo, input logic expDz, input int pokeAt);
        int n;
        bit seen;
        start = 1'b1;
        op    = opSel;
        a     = aIn;
        b     = bIn;
        n     = 0;
        seen  = 1'b0;
        while (n <= 60) begin
            @(posedge clock);
            @(negedge clock);
            if (n == 0) begin
                start = 1'b0;
                chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
            end
            if (pokeAt >= 0 && n == pokeAt) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 32'd3;
                b     = 32'd4;
            end
            if (pokeAt >= 0 && n == pokeAt + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(n), 32'(expLat));
            chk({tag, " hi"}, hi, expHi);
            chk({tag, " lo"}, lo, expLo);
            chk({tag, " div_zero"}, 32'(div_zero), 32'(expDz));
        end
        @(posedge clock);
        @(negedge clock);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " busy_fall"}, 32'(busy), 32'd0);
        chk({tag, " div_zero_low"}, 32'(div_zero), 32'd0);
        chk({tag, " lo_hold"}, lo, expLo);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) pulses++;
        end
        chk({tag, " stray_done"}, 32'(pulses), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        runOp("mul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        runOp("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0, 1'b0, -1);
        runOp("mul_0_5", 1'b1, 32'd0, 32'd5, 32, 32'h0, 32'h0, 1'b0, -1);
        runOp("mul_m5_m6", 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32, 32'h0, 32'h1E, 1'b0, -1);
        runOp("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        runOp("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD, 1'b0, -1);
        runOp("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, -1);
`ifdef MULT_DIV_DIV0_TRAP_EN
        runOp("div_5_0", 1'b0, 32'd5, 32'd0, 0, 32'h0, 32'h8000_0000, 1'b1, -1);
`else
        runOp("div_5_0", 1'b0, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 1'b0, -1);
`endif
        runOp("div_100_7_poke", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 5);
        quiet("after_poke", 40);

        // Reset in the middle of a multiply.
        start = 1'b1;
        op    = 1'b1;
        a     = 32'h0001_2345;
        b     = 32'h0000_0777;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        quiet("after_reset", 50);
        chk("after_reset lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit that answers the multicycle control FSM's MULT/DIV requests. It accepts a one-cycle `start` with operands taken from regA/regB and runs a radix-2 Booth multiply or a restoring divide. It returns a one-cycle `done` pulse together with 32-bit `hi`/`lo` results, which the control FSM then loads into the high/low registers.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported.
- `clock`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `op`  in  1  operation select: 0 = DIV, 1 = MULT. Matches the `divMult` mux encoding.
- `a`  in  32  rs operand (multiplicand or dividend), signed.
- `b`  in  32  rt operand (multiplier or divisor), signed.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse. `hi`/`lo` are valid in that cycle.
- `hi`  out  32  MULT: product[63:32]. DIV: remainder.
- `lo`  out  32  MULT: product[31:0]. DIV: quotient.
- `div_zero`  out  1  high together with `done` when a DIV had b == 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, iteration counter 0.
- IDLE + `start`: latch `op`, `a`, `b`, clear the counter, go to RUN.
- `start` while `busy` is ignored. It is neither queued nor able to abort the current operation.
- MULT: 66-bit working register {A[32:0], Q[31:0], q_1}, with M = b sign-extended to 33 bits.
  - Each RUN cycle: {Q0,q_1}=01 adds M to A; 10 subtracts M from A; 00 and 11 leave A unchanged.
  - The whole register is then arithmetic-shifted right by 1.
  - After 32 iterations go to DONE. `hi` = A[31:0], `lo` = Q.
- DIV: operate on magnitudes |a| and |b| as 32-bit unsigned values. |0x80000000| = 0x80000000.
  - Each RUN cycle is a shift-subtract step: the remainder is restored if the trial result is negative. The quotient bit is 1 otherwise.
  - After 32 iterations go to FIX.
  - FIX negates the quotient if sign(a) != sign(b), negates the remainder if a < 0, then goes to DONE.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0, with no flag.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `hi`/`lo` are written only on entry to DONE. They hold their value until the next completion.
- `div_zero` is 1 only during the DONE cycle of a zero-divide.

## Timing
- Take E0 as the `start` sample edge.
- MULT: RUN on E1..E32. `done` is high in the cycle after E32, i.e. 32 cycles after the start cycle.
- DIV: RUN on E1..E32, FIX on E33. `done` is high in the cycle after E33 (33 cycles).
- Zero-divide with the macro defined: DONE on E0. `done` and `div_zero` are high in the cycle immediately after start.
- `busy` rises the cycle after E0 and falls the cycle after the DONE cycle.
- A new `start` is accepted in the first IDLE cycle. This allows back-to-back operations with a one-cycle gap.
- `reset` low at any time: return immediately to IDLE and clear all outputs. A partial result is never exposed.

## Configuration
- Macro: `MULT_DIV_DIV0_TRAP_EN`.
- Defined: a DIV with b == 0 skips RUN and FIX. It completes via DONE with `div_zero`=1 and leaves `hi`/`lo` unchanged.
- Undefined: `div_zero` is tied to 0 and a zero-divide runs the full 33 cycles.
  - The algorithm gives an unsigned quotient of 0xFFFFFFFF and a remainder of |a|.
  - FIX then applies (b counts as positive).
  - `hi`/`lo` are written.

## Structure
- Shared package `mult_div_pkg` holds:
  - the state enum typedef (IDLE/RUN/FIX/DONE);
  - op constants `OP_DIV`=1'b0 and `OP_MULT`=1'b1;
  - `MD_ITERS`=32.
- The control FSM imports the same op constants.
- One combinational sub-module, `booth_step`: takes {A, Q, q_1} and M, returns the next shifted register. The FSM, counter and divider datapath stay in the top module.

## Test plan
- MULT a=7, b=0xFFFFFFFD (-3) -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` exactly 32 cycles after the start cycle.
- MULT a=b=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000. Then immediately MULT 0×5 -> `hi`=`lo`=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `done` 33 cycles after start. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV a=5, b=0:
  - with the macro: `done`+`div_zero` in the next cycle, `hi`/`lo` unchanged;
  - without it: after 33 cycles `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=0.
- Pulse `start` (MULT 3×4) while busy with DIV 100/7 -> ignored. Result `lo`=14, `hi`=2, with a single `done` pulse.
- Pull `reset` low at iteration 10 of a MULT -> `busy`=`done`=0 and `hi`=`lo`=0 immediately. No `done` follows after release.
